// File: rtl/alu_exec_sequencer.sv
// Three-state execute sequencer (IDLE -> EXEC -> WB) driving a 4-bit ALU and owning acc/regfile/carry.
// Optional zero flag output enabled by defining ALU_SEQ_ZERO_FLAG_EN.
module alu_exec_sequencer #(
  parameter int DATA_WIDTH = 4,
  parameter int OC_WIDTH   = 3,
  parameter int REG_COUNT  = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [7:0]            instr_i,
  input  logic                  instr_valid_i,
  output logic                  instr_ready_o,
  output logic [DATA_WIDTH-1:0] alu_a_o,
  output logic [DATA_WIDTH-1:0] alu_b_o,
  output logic [OC_WIDTH-1:0]   alu_oc_o,
  input  logic [DATA_WIDTH-1:0] alu_result_i,
  input  logic                  alu_carry_i,
  output logic [DATA_WIDTH-1:0] acc_o,
  output logic                  carry_flag_o,
  output logic                  done_o,
  output logic                  illegal_o
`ifdef ALU_SEQ_ZERO_FLAG_EN
  ,output logic                 zero_flag_o
`endif
);

  localparam int RW = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_LDR  = 4'h2;
  localparam logic [3:0] OP_STR  = 4'h3;
  localparam logic [3:0] OP_ADD  = 4'h4;
  localparam logic [3:0] OP_SUB  = 4'h5;
  localparam logic [3:0] OP_AND  = 4'h6;
  localparam logic [3:0] OP_OR   = 4'h7;
  localparam logic [3:0] OP_XOR  = 4'h8;
  localparam logic [3:0] OP_ADDI = 4'h9;
  localparam logic [3:0] OP_SUBI = 4'hA;

  localparam logic [OC_WIDTH-1:0] OC_NONE = 3'b000;
  localparam logic [OC_WIDTH-1:0] OC_ADD  = 3'b100;
  localparam logic [OC_WIDTH-1:0] OC_SUB  = 3'b110;
  localparam logic [OC_WIDTH-1:0] OC_AND  = 3'b010;
  localparam logic [OC_WIDTH-1:0] OC_OR   = 3'b011;
  localparam logic [OC_WIDTH-1:0] OC_XOR  = 3'b001;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_EXEC = 2'b01,
    S_WB   = 2'b10
  } state_e;

  state_e                state_q;
  logic [3:0]            op_q;
  logic [RW-1:0]         idx_q;
  logic [DATA_WIDTH-1:0] acc_q;
  logic [DATA_WIDTH-1:0] rf_q [REG_COUNT];
  logic                  carry_q;
  logic                  ready_q;
  logic                  done_q;
  logic                  illegal_q;
  logic [DATA_WIDTH-1:0] alu_a_q;
  logic [DATA_WIDTH-1:0] alu_b_q;
  logic [OC_WIDTH-1:0]   alu_oc_q;
  logic [OC_WIDTH-1:0]   oc_d;
  logic [DATA_WIDTH-1:0] b_d;
  logic [DATA_WIDTH-1:0] imm_s;
  logic [DATA_WIDTH-1:0] rf_rd_s;
  logic                  acc_we_s;
  logic [DATA_WIDTH-1:0] acc_new_s;
`ifdef ALU_SEQ_ZERO_FLAG_EN
  logic                  zero_q;
`endif

  assign imm_s   = DATA_WIDTH'(instr_i[3:0]);
  assign rf_rd_s = rf_q[instr_i[RW-1:0]];

  // Decode the incoming instruction into the operand-B and opcode values presented during EXEC.
  always_comb begin
    oc_d = OC_NONE;
    b_d  = imm_s;
    case (instr_i[7:4])
      OP_LDR, OP_STR: b_d = rf_rd_s;
      OP_ADD:  begin oc_d = OC_ADD; b_d = rf_rd_s; end
      OP_SUB:  begin oc_d = OC_SUB; b_d = rf_rd_s; end
      OP_AND:  begin oc_d = OC_AND; b_d = rf_rd_s; end
      OP_OR:   begin oc_d = OC_OR;  b_d = rf_rd_s; end
      OP_XOR:  begin oc_d = OC_XOR; b_d = rf_rd_s; end
      OP_ADDI: oc_d = OC_ADD;
      OP_SUBI: oc_d = OC_SUB;
      default: oc_d = OC_NONE;
    endcase
  end

  // Select the accumulator write-back value for the instruction in EXEC.
  always_comb begin
    acc_we_s  = 1'b0;
    acc_new_s = acc_q;
    case (op_q)
      OP_LDI, OP_LDR: begin acc_we_s = 1'b1; acc_new_s = alu_b_q; end
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_ADDI, OP_SUBI: begin
        acc_we_s  = 1'b1;
        acc_new_s = alu_result_i;
      end
      default: acc_we_s = 1'b0;
    endcase
  end

  // Sequencer FSM with architectural state and registered ALU/handshake outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      op_q      <= 4'h0;
      idx_q     <= '0;
      acc_q     <= '0;
      carry_q   <= 1'b0;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_oc_q  <= OC_NONE;
      for (int i = 0; i < REG_COUNT; i++) rf_q[i] <= '0;
`ifdef ALU_SEQ_ZERO_FLAG_EN
      zero_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q    <= 1'b0;
          illegal_q <= 1'b0;
          if (instr_valid_i) begin
            op_q     <= instr_i[7:4];
            idx_q    <= instr_i[RW-1:0];
            alu_a_q  <= acc_q;
            alu_b_q  <= b_d;
            alu_oc_q <= oc_d;
            ready_q  <= 1'b0;
            state_q  <= S_EXEC;
          end else begin
            state_q  <= S_IDLE;
          end
        end
        S_EXEC: begin
          state_q  <= S_WB;
          done_q   <= 1'b1;
          alu_oc_q <= OC_NONE;
          if (acc_we_s) begin
            acc_q <= acc_new_s;
`ifdef ALU_SEQ_ZERO_FLAG_EN
            zero_q <= (acc_new_s == '0);
`endif
          end
          case (op_q)
            OP_STR: rf_q[idx_q] <= acc_q;
            OP_ADD, OP_SUB, OP_ADDI, OP_SUBI: carry_q <= alu_carry_i;
            OP_NOP, OP_LDI, OP_LDR, OP_AND, OP_OR, OP_XOR: illegal_q <= 1'b0;
            default: illegal_q <= 1'b1;
          endcase
        end
        S_WB: begin
          done_q    <= 1'b0;
          illegal_q <= 1'b0;
          ready_q   <= 1'b1;
          state_q   <= S_IDLE;
        end
        default: begin
          done_q    <= 1'b0;
          illegal_q <= 1'b0;
          ready_q   <= 1'b1;
          alu_oc_q  <= OC_NONE;
          state_q   <= S_IDLE;
        end
      endcase
    end
  end

  assign instr_ready_o = ready_q;
  assign alu_a_o       = alu_a_q;
  assign alu_b_o       = alu_b_q;
  assign alu_oc_o      = alu_oc_q;
  assign acc_o         = acc_q;
  assign carry_flag_o  = carry_q;
  assign done_o        = done_q;
  assign illegal_o     = illegal_q;
`ifdef ALU_SEQ_ZERO_FLAG_EN
  assign zero_flag_o   = zero_q;
`endif

endmodule

// File: tb/tb_alu_exec_sequencer.sv
// Directed bench for alu_exec_sequencer with a behavioural 4-bit ALU in the loop.
module tb_alu_exec_sequencer;

  logic       clk;
  logic       rst_n;
  logic [7:0] instr;
  logic       valid;
  logic       ready;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [2:0] alu_oc;
  logic [3:0] alu_result;
  logic       alu_carry;
  logic [3:0] acc;
  logic       carry_flag;
  logic       done;
  logic       illegal;
`ifdef ALU_SEQ_ZERO_FLAG_EN
  logic       zero_flag;
`endif

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [7:0] instr;
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] oc;
    logic [3:0] acc;
    logic       c;
    logic       ill;
    logic       z;
  } vec_t;

  vec_t vecs [24];

  alu_exec_sequencer dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .instr_i       (instr),
    .instr_valid_i (valid),
    .instr_ready_o (ready),
    .alu_a_o       (alu_a),
    .alu_b_o       (alu_b),
    .alu_oc_o      (alu_oc),
    .alu_result_i  (alu_result),
    .alu_carry_i   (alu_carry),
    .acc_o         (acc),
    .carry_flag_o  (carry_flag),
    .done_o        (done),
    .illegal_o     (illegal)
`ifdef ALU_SEQ_ZERO_FLAG_EN
    ,.zero_flag_o  (zero_flag)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU; junk result/carry on 000 so ignored outputs are exercised.
  always_comb begin
    alu_result = 4'hA;
    alu_carry  = 1'b1;
    case (alu_oc)
      3'b100: {alu_carry, alu_result} = {1'b0, alu_a} + {1'b0, alu_b};
      3'b110: {alu_carry, alu_result} = {1'b0, alu_a} + {1'b0, ~alu_b} + 5'd1;
      3'b010: begin alu_result = alu_a & alu_b; alu_carry = 1'b0; end
      3'b011: begin alu_result = alu_a | alu_b; alu_carry = 1'b0; end
      3'b001: begin alu_result = alu_a ^ alu_b; alu_carry = 1'b0; end
      default: ;
    endcase
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Starts and ends on a falling edge with the DUT in IDLE.
  task automatic run_vec(input vec_t v, input int n);
    chk($sformatf("v%0d ready", n), 8'(ready), 8'h01);
    instr = v.instr;
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    chk($sformatf("v%0d exec_a", n), 8'(alu_a), 8'(v.a));
    chk($sformatf("v%0d exec_b", n), 8'(alu_b), 8'(v.b));
    chk($sformatf("v%0d exec_oc", n), 8'(alu_oc), 8'(v.oc));
    chk($sformatf("v%0d exec_ready_done", n), {6'd0, ready, done}, 8'h00);
    @(negedge clk);
    chk($sformatf("v%0d wb_done_ill", n), {6'd0, done, illegal}, {6'd0, 1'b1, v.ill});
    chk($sformatf("v%0d wb_acc", n), 8'(acc), 8'(v.acc));
    chk($sformatf("v%0d wb_carry", n), 8'(carry_flag), 8'(v.c));
    chk($sformatf("v%0d wb_oc", n), 8'(alu_oc), 8'h00);
`ifdef ALU_SEQ_ZERO_FLAG_EN
    chk($sformatf("v%0d wb_zero", n), 8'(zero_flag), 8'(v.z));
`endif
    @(negedge clk);
    chk($sformatf("v%0d idle_ready_done", n), {6'd0, ready, done}, 8'h02);
  endtask

  initial begin
    //               instr   a     b     oc      acc   c     ill   z
    vecs[0]  = '{8'h19, 4'h0, 4'h9, 3'b000, 4'h9, 1'b0, 1'b0, 1'b0}; // LDI 9
    vecs[1]  = '{8'h99, 4'h9, 4'h9, 3'b100, 4'h2, 1'b1, 1'b0, 1'b0}; // ADDI 9
    vecs[2]  = '{8'h13, 4'h2, 4'h3, 3'b000, 4'h3, 1'b1, 1'b0, 1'b0}; // LDI 3
    vecs[3]  = '{8'h32, 4'h3, 4'h0, 3'b000, 4'h3, 1'b1, 1'b0, 1'b0}; // STR r2
    vecs[4]  = '{8'h15, 4'h3, 4'h5, 3'b000, 4'h5, 1'b1, 1'b0, 1'b0}; // LDI 5
    vecs[5]  = '{8'h52, 4'h5, 4'h3, 3'b110, 4'h2, 1'b1, 1'b0, 1'b0}; // SUB r2
    vecs[6]  = '{8'h12, 4'h2, 4'h2, 3'b000, 4'h2, 1'b1, 1'b0, 1'b0}; // LDI 2
    vecs[7]  = '{8'hA3, 4'h2, 4'h3, 3'b110, 4'hF, 1'b0, 1'b0, 1'b0}; // SUBI 3
    vecs[8]  = '{8'h1F, 4'hF, 4'hF, 3'b000, 4'hF, 1'b0, 1'b0, 1'b0}; // LDI F
    vecs[9]  = '{8'h91, 4'hF, 4'h1, 3'b100, 4'h0, 1'b1, 1'b0, 1'b1}; // ADDI 1
    vecs[10] = '{8'h1C, 4'h0, 4'hC, 3'b000, 4'hC, 1'b1, 1'b0, 1'b0}; // LDI C
    vecs[11] = '{8'h31, 4'hC, 4'h0, 3'b000, 4'hC, 1'b1, 1'b0, 1'b0}; // STR r1
    vecs[12] = '{8'h1A, 4'hC, 4'hA, 3'b000, 4'hA, 1'b1, 1'b0, 1'b0}; // LDI A
    vecs[13] = '{8'h61, 4'hA, 4'hC, 3'b010, 4'h8, 1'b1, 1'b0, 1'b0}; // AND r1
    vecs[14] = '{8'h72, 4'h8, 4'h3, 3'b011, 4'hB, 1'b1, 1'b0, 1'b0}; // OR r2
    vecs[15] = '{8'h21, 4'hB, 4'hC, 3'b000, 4'hC, 1'b1, 1'b0, 1'b0}; // LDR r1
    vecs[16] = '{8'h81, 4'hC, 4'hC, 3'b001, 4'h0, 1'b1, 1'b0, 1'b1}; // XOR r1
    vecs[17] = '{8'h05, 4'h0, 4'h5, 3'b000, 4'h0, 1'b1, 1'b0, 1'b1}; // NOP
    vecs[18] = '{8'hB3, 4'h0, 4'h3, 3'b000, 4'h0, 1'b1, 1'b1, 1'b1}; // illegal B
    vecs[19] = '{8'h14, 4'h0, 4'h4, 3'b000, 4'h4, 1'b1, 1'b0, 1'b0}; // LDI 4
    vecs[20] = '{8'h30, 4'h4, 4'h0, 3'b000, 4'h4, 1'b1, 1'b0, 1'b0}; // STR r0
    vecs[21] = '{8'h80, 4'h4, 4'h4, 3'b001, 4'h0, 1'b1, 1'b0, 1'b1}; // XOR r0
    vecs[22] = '{8'h11, 4'h0, 4'h1, 3'b000, 4'h1, 1'b1, 1'b0, 1'b0}; // LDI 1
    vecs[23] = '{8'h52, 4'h1, 4'h3, 3'b110, 4'hE, 1'b0, 1'b0, 1'b0}; // SUB r2

    rst_n = 1'b0;
    valid = 1'b0;
    instr = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst acc_carry", {3'd0, carry_flag, acc}, 8'h00);
    chk("rst ready_done_ill", {5'd0, ready, done, illegal}, 8'h04);
    chk("rst alu_outs", {1'b0, alu_oc, alu_a}, 8'h00);
    chk("rst alu_b", 8'(alu_b), 8'h00);
`ifdef ALU_SEQ_ZERO_FLAG_EN
    chk("rst zero", 8'(zero_flag), 8'h00);
`endif
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle hold", {5'd0, ready, done, illegal}, 8'h04);

    for (int i = 0; i < 24; i++) run_vec(vecs[i], i);

    // Illegal opcode with valid held high; a changed instr_i in flight must be ignored.
    instr = 8'hE7;
    valid = 1'b1;
    @(negedge clk);
    instr = 8'h1F;
    chk("ill exec ready", 8'(ready), 8'h00);
    chk("ill exec done", 8'(done), 8'h00);
    @(negedge clk);
    chk("ill wb ready", 8'(ready), 8'h00);
    chk("ill wb done_ill", {6'd0, done, illegal}, 8'h03);
    chk("ill wb acc", 8'(acc), 8'h0E);
    @(negedge clk);
    chk("ill idle ready", 8'(ready), 8'h01);
    chk("ill idle done_ill", {6'd0, done, illegal}, 8'h00);
    instr = 8'h17;
    @(negedge clk);
    valid = 1'b0;
    chk("next accepted ready", 8'(ready), 8'h00);
    chk("next exec b", 8'(alu_b), 8'h07);
    @(negedge clk);
    chk("next wb acc", 8'(acc), 8'h07);
    chk("next wb done_ill", {6'd0, done, illegal}, 8'h02);
    @(negedge clk);

    // Reset during EXEC of LDI 5 discards it.
    instr = 8'h15;
    valid = 1'b1;
    @(negedge clk);
    chk("mid exec entered", 8'(ready), 8'h00);
    valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid rst acc_carry", {3'd0, carry_flag, acc}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid rst ready_done", {6'd0, ready, done}, 8'h02);
    @(negedge clk);
    chk("post rst no done", {5'd0, ready, done, illegal}, 8'h04);
    chk("post rst acc", 8'(acc), 8'h00);
`ifdef ALU_SEQ_ZERO_FLAG_EN
    chk("post rst zero", 8'(zero_flag), 8'h00);
`endif
    // Register file cleared by reset (r2 previously held 3).
    run_vec('{8'h22, 4'h0, 4'h0, 3'b000, 4'h0, 1'b0, 1'b0, 1'b1}, 99);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
